trivium_stream_decryptor: RTL and testbench
===========================================

TRIVIUM_STREAM_DECRYPTOR -- requirements
Module: trivium_stream_decryptor

Interface
REQ-001 Parameter: CNT_W, default 16, width of the decrypted-byte counter.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: seed_valid  input  1  seed byte present this cycle.
REQ-005 Port: seed  input  8  session seed.
REQ-006 Port: resync  input  1  abort the session and restore the init state.
REQ-007 Port: ct_valid  input  1  ciphertext byte valid.
REQ-008 Port: ct_data  input  8  ciphertext byte.
REQ-009 Port: ct_ready  output  1  ciphertext byte is accepted when ct_valid and ct_ready are both high.
REQ-010 Port: pt_valid  output  1  plaintext byte valid.
REQ-011 Port: pt_data  output  8  plaintext byte.
REQ-012 Port: pt_ready  input  1  downstream accepts the plaintext byte.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: byte_count  output  CNT_W  count of completed plaintext handshakes since the seed was loaded.

Function
REQ-015 The block SHALL contain three 64-bit shift registers s1, s2, s3 with init values 0x23A2B, 0x2A892 and 0xF4511.
REQ-016 Seed load SHALL set each register's upper 48 bits to 0 and its lower 16 bits as follows:
- s1 = {seed, seed}
- s2 = {seed, ~seed[3:0], seed[7:4]}
- s3 = {seed, seed ^ 0xA5}
REQ-017 Each keystream step SHALL shift every register left by one bit; the new LSB is the XOR of these taps, all taken from pre-shift values:
- s1: s2[0], s3[1], s1[5], s2[7], s3[13], s1[31], s2[47], s3[60]
- s2: s3[3], s1[1], s2[2], s3[19], s1[23]
- s3: s1[5], s2[2], s3[4], s1[17], s2[29], s3[63], s1[10], s2[40]
REQ-018 Each step SHALL produce the bit s1[0]^s2[0]^s3[0] (pre-shift values) and shift it into an 8-bit keystream register ks, which is cleared at the start of each byte; after 8 steps the first-generated bit SHALL be at ks[7].
REQ-019 The FSM SHALL have the states IDLE, GEN, WAIT_CT and OUT.
REQ-020 IDLE: when seed_valid is high and seed is neither 0x00 nor 0xFF, the block SHALL load the seed, clear byte_count, clear the step counter and go to GEN.
REQ-021 IDLE: when seed_valid is high with seed 0x00 or 0xFF, the block SHALL ignore it and remain in IDLE.
REQ-022 GEN: the block SHALL perform exactly one step per cycle for 8 cycles using a 3-bit step counter, then go to WAIT_CT.
REQ-023 WAIT_CT: ct_ready SHALL be 1, and only in this state; on the handshake the block SHALL register pt_data = ct_data ^ ks and go to OUT.
REQ-024 OUT: pt_valid SHALL be 1; pt_data SHALL hold stable until pt_ready is high.
REQ-025 OUT: on the plaintext handshake the block SHALL increment byte_count (wrapping modulo 2^CNT_W), clear ks and go to GEN.
REQ-026 Latency: the first ct_ready SHALL occur 8 cycles after seed acceptance; pt_valid SHALL rise the cycle after the ct handshake.
REQ-027 resync SHALL take priority over every other input in any state: on the next edge the registers reload their init values, ks, the step counter and byte_count clear, pt_valid drops and the FSM goes to IDLE; any pending plaintext byte is discarded.
REQ-028 When seed_valid and resync are high in the same cycle, resync SHALL win and the seed is discarded.
REQ-029 seed_valid outside IDLE SHALL be ignored.
REQ-030 ct_valid outside WAIT_CT SHALL NOT be accepted.
REQ-031 The keystream sequence SHALL be bit-identical to the companion encryptor's keystream for the same seed, so that encrypt followed by decrypt returns the original byte.

Reset
REQ-032 While rst_n is low, the registers SHALL hold their init values, the FSM is in IDLE, and ks, the step counter and byte_count are 0.
REQ-033 While rst_n is low, the outputs SHALL be: ct_ready = 0, pt_valid = 0, pt_data = 0x00, busy = 0.
REQ-034 Reset deassertion SHALL produce no output activity until a valid seed is accepted.

Structure
REQ-035 A shared package SHALL hold the init constants, the forbidden seed values 0x00 and 0xFF, the 0xA5 mask and the FSM state encoding.
REQ-036 The register triple, seeding logic and step logic SHALL form one sub-module, trivium_keystream_core, shared with the encryptor.

Verification
REQ-037 Bench SHALL cover: seed 0x00, then 0xFF, then 0x5A -> first two ignored (busy stays 0); 0x5A accepted; ct_ready rises exactly 8 cycles later.
REQ-038 Bench SHALL cover: seed 0x5A, ct 0x00 -> pt_data equals the model keystream byte; byte_count = 1 after pt_ready.
REQ-039 Bench SHALL cover: pt_ready held low for 5 cycles -> pt_valid and pt_data stable; ct_ready = 0 throughout.
REQ-040 Bench SHALL cover: resync asserted mid-GEN, then seed 0x5A again -> keystream restarts identical to REQ-038; byte_count = 0.
REQ-041 Bench SHALL cover: encryptor to decryptor loopback, seed 0x3C, 256 random bytes -> every output equals its input; byte_count = 256.
REQ-042 Bench SHALL cover: seed_valid and resync high in the same cycle from IDLE -> FSM stays IDLE; registers hold their init values.

Source files
------------

// File: rtl/trivium_stream_decryptor_pkg.sv
// Shared constants and FSM encoding for the Trivium-style stream decryptor
// and its companion keystream core.
package trivium_stream_decryptor_pkg;

    localparam logic [63:0] S1_INIT = 64'h0000_0000_0002_3A2B;
    localparam logic [63:0] S2_INIT = 64'h0000_0000_0002_A892;
    localparam logic [63:0] S3_INIT = 64'h0000_0000_000F_4511;

    localparam logic [7:0] SEED_ZERO = 8'h00;
    localparam logic [7:0] SEED_ONES = 8'hFF;
    localparam logic [7:0] SEED_MASK = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        WAIT_CT,
        OUT
    } state_t;

    // All-zero and all-one seeds give degenerate keystreams and are refused.
    function automatic logic seed_ok(input logic [7:0] s);
        return (s != SEED_ZERO) && (s != SEED_ONES);
    endfunction

endpackage

// File: rtl/trivium_keystream_core.sv
// Three coupled 64-bit shift registers producing one keystream bit per step;
// shared verbatim with the encryptor so both sides stay bit-identical.
module trivium_keystream_core
    import trivium_stream_decryptor_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic       ks_bit
);

    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] s3;
    logic        fb1;
    logic        fb2;
    logic        fb3;

    // Output and feedback taps all come from the pre-shift register values.
    assign ks_bit = s1[0] ^ s2[0] ^ s3[0];
    assign fb1 = s2[0] ^ s3[1] ^ s1[5] ^ s2[7] ^ s3[13] ^ s1[31] ^ s2[47] ^ s3[60];
    assign fb2 = s3[3] ^ s1[1] ^ s2[2] ^ s3[19] ^ s1[23];
    assign fb3 = s1[5] ^ s2[2] ^ s3[4] ^ s1[17] ^ s2[29] ^ s3[63] ^ s1[10] ^ s2[40];

    // NOTE: state registers use non-blocking assignments so every tap above
    // sees the same pre-edge snapshot regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= S1_INIT;
            s2 <= S2_INIT;
            s3 <= S3_INIT;
        end else if (restart) begin
            s1 <= S1_INIT;
            s2 <= S2_INIT;
            s3 <= S3_INIT;
        end else if (load) begin
            s1 <= {48'd0, seed, seed};
            s2 <= {48'd0, seed, ~seed[3:0], seed[7:4]};
            s3 <= {48'd0, seed, seed ^ SEED_MASK};
        end else if (step) begin
            s1 <= {s1[62:0], fb1};
            s2 <= {s2[62:0], fb2};
            s3 <= {s3[62:0], fb3};
        end
    end

endmodule

// File: rtl/trivium_stream_decryptor.sv
// Byte-wide stream decryptor: generates 8 keystream bits per byte, then XORs
// them into one accepted ciphertext byte and hands the plaintext downstream.
module trivium_stream_decryptor
    import trivium_stream_decryptor_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_valid,
    input  logic [7:0]       seed,
    input  logic             resync,
    input  logic             ct_valid,
    input  logic [7:0]       ct_data,
    output logic             ct_ready,
    output logic             pt_valid,
    output logic [7:0]       pt_data,
    input  logic             pt_ready,
    output logic             busy,
    output logic [CNT_W-1:0] byte_count
);

    state_t     state;
    logic [2:0] step_cnt;
    logic [7:0] ks;
    logic       ks_bit;
    logic       seed_take;

    assign seed_take = (state == IDLE) && seed_valid && seed_ok(seed) && !resync;

    trivium_keystream_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(resync),
        .load   (seed_take),
        .seed   (seed),
        .step   (state == GEN),
        .ks_bit (ks_bit)
    );

    // Outputs are registered and updated alongside the state so they never
    // glitch; ct_ready mirrors WAIT_CT, pt_valid mirrors OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step_cnt   <= 3'd0;
            ks         <= 8'd0;
            byte_count <= '0;
            pt_data    <= 8'd0;
            pt_valid   <= 1'b0;
            ct_ready   <= 1'b0;
            busy       <= 1'b0;
        end else if (resync) begin
            state      <= IDLE;
            step_cnt   <= 3'd0;
            ks         <= 8'd0;
            byte_count <= '0;
            pt_data    <= 8'd0;
            pt_valid   <= 1'b0;
            ct_ready   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (seed_take) begin
                        state      <= GEN;
                        step_cnt   <= 3'd0;
                        ks         <= 8'd0;
                        byte_count <= '0;
                        busy       <= 1'b1;
                    end
                end
                GEN: begin
                    ks       <= {ks[6:0], ks_bit};
                    step_cnt <= step_cnt + 3'd1;
                    if (step_cnt == 3'd7) begin
                        state    <= WAIT_CT;
                        ct_ready <= 1'b1;
                    end
                end
                WAIT_CT: begin
                    if (ct_valid) begin
                        pt_data  <= ct_data ^ ks;
                        pt_valid <= 1'b1;
                        ct_ready <= 1'b0;
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (pt_ready) begin
                        pt_valid   <= 1'b0;
                        byte_count <= byte_count + CNT_W'(1);
                        ks         <= 8'd0;
                        step_cnt   <= 3'd0;
                        state      <= GEN;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ct_ready <= 1'b0;
                    pt_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trivium_stream_decryptor.sv
// Scoreboard bench for trivium_stream_decryptor: a bench-side keystream model
// acts as the encryptor and predicts every plaintext byte.
module tb_trivium_stream_decryptor;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             seed_valid = 1'b0;
    logic [7:0]       seed = 8'h00;
    logic             resync = 1'b0;
    logic             ct_valid = 1'b0;
    logic [7:0]       ct_data = 8'h00;
    logic             ct_ready;
    logic             pt_valid;
    logic [7:0]       pt_data;
    logic             pt_ready = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] byte_count;

    int n_checks = 0;
    int n_fail   = 0;
    int bc_model = 0;

    logic [7:0]  sb[$];
    logic [63:0] m1, m2, m3;
    logic [7:0]  first_ks;
    logic [7:0]  k;
    logic [7:0]  pt;

    trivium_stream_decryptor #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_valid(seed_valid),
        .seed      (seed),
        .resync    (resync),
        .ct_valid  (ct_valid),
        .ct_data   (ct_data),
        .ct_ready  (ct_ready),
        .pt_valid  (pt_valid),
        .pt_data   (pt_data),
        .pt_ready  (pt_ready),
        .busy      (busy),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference keystream written directly from the register/tap description.
    task automatic model_seed(input logic [7:0] s);
        m1 = {48'd0, s, s};
        m2 = {48'd0, s, ~s[3:0], s[7:4]};
        m3 = {48'd0, s, s ^ 8'hA5};
    endtask

    task automatic model_byte(output logic [7:0] b);
        logic n1, n2, n3;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b  = {b[6:0], m1[0] ^ m2[0] ^ m3[0]};
            n1 = m2[0] ^ m3[1] ^ m1[5] ^ m2[7] ^ m3[13] ^ m1[31] ^ m2[47] ^ m3[60];
            n2 = m3[3] ^ m1[1] ^ m2[2] ^ m3[19] ^ m1[23];
            n3 = m1[5] ^ m2[2] ^ m3[4] ^ m1[17] ^ m2[29] ^ m3[63] ^ m1[10] ^ m2[40];
            m1 = {m1[62:0], n1};
            m2 = {m2[62:0], n2};
            m3 = {m3[62:0], n3};
        end
    endtask

    task automatic load_seed(input logic [7:0] s);
        seed_valid = 1'b1;
        seed       = s;
        tick();
        seed_valid = 1'b0;
        model_seed(s);
        bc_model = 0;
    endtask

    task automatic send_byte(input logic [7:0] c, input logic [7:0] exp_pt);
        int n;
        n = 0;
        while (!ct_ready && n < 20) begin
            tick();
            n++;
        end
        if (!ct_ready) check("ct_ready_timeout", 64'd0, 64'd1);
        ct_valid = 1'b1;
        ct_data  = c;
        sb.push_back(exp_pt);
        tick();
        ct_valid = 1'b0;
    endtask

    task automatic recv_byte(input int delay);
        int n;
        n = 0;
        while (!pt_valid && n < 20) begin
            tick();
            n++;
        end
        if (!pt_valid) check("pt_valid_timeout", 64'd0, 64'd1);
        repeat (delay) tick();
        pt_ready = 1'b1;
        tick();
        pt_ready = 1'b0;
    endtask

    // Plaintext handshakes complete at the next rising edge; pop and compare here.
    always @(negedge clk) begin
        if (rst_n && pt_valid && pt_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_pt", 64'd1, 64'd0);
            end else begin
                check("pt_data", {56'd0, pt_data}, {56'd0, sb.pop_front()});
                bc_model++;
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_ct_ready", {63'd0, ct_ready}, 64'd0);
        check("rst_pt_valid", {63'd0, pt_valid}, 64'd0);
        check("rst_pt_data", {56'd0, pt_data}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_byte_count", {48'd0, byte_count}, 64'd0);
        check("rst_s1", dut.u_core.s1, 64'h23A2B);
        check("rst_s2", dut.u_core.s2, 64'h2A892);
        check("rst_s3", dut.u_core.s3, 64'hF4511);
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_busy", {63'd0, busy}, 64'd0);
        check("post_rst_ct_ready", {63'd0, ct_ready}, 64'd0);
        check("post_rst_pt_valid", {63'd0, pt_valid}, 64'd0);

        // Forbidden seeds ignored, then 0x5A accepted; ct_valid during GEN refused
        seed_valid = 1'b1;
        seed = 8'h00;
        tick();
        check("seed00_busy", {63'd0, busy}, 64'd0);
        seed = 8'hFF;
        tick();
        check("seedFF_busy", {63'd0, busy}, 64'd0);
        seed_valid = 1'b0;
        load_seed(8'h5A);
        check("seed5A_busy", {63'd0, busy}, 64'd1);
        ct_valid = 1'b1;
        ct_data  = 8'hEE;
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) ct_valid = 1'b0;
            tick();
            check($sformatf("ct_ready_lat_%0d", i), {63'd0, ct_ready}, {63'd0, i == 8});
        end

        // First byte with ct 0x00 reveals the keystream; backpressure for 5 cycles
        model_byte(first_ks);
        ct_valid = 1'b1;
        ct_data  = 8'h00;
        sb.push_back(first_ks);
        tick();
        ct_valid = 1'b0;
        check("pt_valid_rise", {63'd0, pt_valid}, 64'd1);
        check("ct_ready_after_hs", {63'd0, ct_ready}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_pt_valid", {63'd0, pt_valid}, 64'd1);
            check("hold_pt_data", {56'd0, pt_data}, {56'd0, first_ks});
            check("hold_ct_ready", {63'd0, ct_ready}, 64'd0);
        end
        pt_ready = 1'b1;
        tick();
        pt_ready = 1'b0;
        check("byte_count_1", {48'd0, byte_count}, 64'd1);
        check("pt_valid_drop", {63'd0, pt_valid}, 64'd0);

        // Resync mid-GEN, then reseed: keystream restarts from the first byte
        repeat (3) tick();
        resync = 1'b1;
        tick();
        resync = 1'b0;
        bc_model = 0;
        check("resync_busy", {63'd0, busy}, 64'd0);
        check("resync_byte_count", {48'd0, byte_count}, 64'd0);
        load_seed(8'h5A);
        model_byte(k);
        send_byte(8'h00, first_ks);
        recv_byte(0);
        check("restart_byte_count", {48'd0, byte_count}, 64'd1);

        // Resync while a plaintext byte is pending discards it
        model_byte(k);
        send_byte(8'h11, 8'h00);
        void'(sb.pop_back());
        check("pending_pt_valid", {63'd0, pt_valid}, 64'd1);
        resync = 1'b1;
        tick();
        resync = 1'b0;
        check("discard_pt_valid", {63'd0, pt_valid}, 64'd0);
        check("discard_ct_ready", {63'd0, ct_ready}, 64'd0);

        // seed_valid and resync together from IDLE: resync wins
        seed_valid = 1'b1;
        seed   = 8'h5A;
        resync = 1'b1;
        tick();
        seed_valid = 1'b0;
        resync = 1'b0;
        check("tie_busy", {63'd0, busy}, 64'd0);
        check("tie_s1", dut.u_core.s1, 64'h23A2B);
        check("tie_s2", dut.u_core.s2, 64'h2A892);
        check("tie_s3", dut.u_core.s3, 64'hF4511);
        repeat (2) tick();
        check("tie_busy_later", {63'd0, busy}, 64'd0);

        // Loopback: bench model encrypts 256 random bytes under seed 0x3C
        load_seed(8'h3C);
        for (int i = 0; i < 256; i++) begin
            pt = 8'($urandom_range(0, 255));
            model_byte(k);
            send_byte(pt ^ k, pt);
            recv_byte(int'($urandom_range(0, 3)));
        end
        tick();
        check("loop_byte_count", {48'd0, byte_count}, 64'd256);
        check("loop_handshakes", 64'(bc_model), 64'd256);
        check("loop_sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
